// File: rtl/matmul_result_drain.sv
// Ping-pong drain of completed NxN result tiles, streamed row-major one element per handshake.
// Latency: a tile accepted into an empty buffer shows element (0,0) the next cycle; 1 element/cycle after that.
// Backpressure: in_ready drops while both banks are full; out_* hold stable while out_ready is low.
// Optional DRAIN_RELU_EN: negative elements are presented as 0; the banks always keep raw values.
module matmul_result_drain #(
   parameter int N  = 4,
   parameter int DW = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N*N*DW-1:0]      in_tile,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [DW-1:0]          out_data,
   output logic [$clog2(N)-1:0]   out_row,
   output logic [$clog2(N)-1:0]   out_col,
   output logic                   out_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   busy
);

   localparam int NE = N * N;
   localparam int IW = $clog2(NE);
   localparam int RW = $clog2(N);
   localparam logic [IW-1:0] LAST_IDX = IW'(NE - 1);

   // Two tile banks; contents are never reset, occupancy is tracked by r_count
   logic [NE*DW-1:0] r_bank [2];
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_count;
   logic [IW-1:0]    r_idx;

   logic             w_valid;
   logic             w_accept;
   logic             w_hs;
   logic             w_at_last;
   logic             w_release;
   logic [NE*DW-1:0] w_rd_tile;
   logic [DW-1:0]    w_elem;
   logic [DW-1:0]    w_data;

   // in_ready and out_valid come straight from the occupancy register, so
   // neither handshake input can loop back into its own ready/valid.
   assign in_ready  = (r_count != 2'd2);
   assign w_valid   = (r_count != 2'd0);
   assign w_accept  = in_valid && in_ready;
   assign w_hs      = w_valid && out_ready;
   assign w_at_last = (r_idx == LAST_IDX);
   assign w_release = w_hs && w_at_last;

   assign w_rd_tile = r_bank[r_rd_ptr];
   assign w_elem    = w_rd_tile[r_idx*DW +: DW];

`ifdef DRAIN_RELU_EN
   assign w_data = w_elem[DW-1] ? '0 : w_elem;
`else
   assign w_data = w_elem;
`endif

   // Outputs are forced to zero whenever nothing is being presented
   assign out_valid = w_valid;
   assign out_data  = w_valid ? w_data : '0;
   assign out_row   = w_valid ? RW'(int'(r_idx) / N) : '0;
   assign out_col   = w_valid ? RW'(int'(r_idx) % N) : '0;
   assign out_last  = w_valid && w_at_last;
   assign busy      = w_valid;

   // Capture a whole tile into the free bank in one cycle
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_bank[r_wr_ptr] <= in_tile;
      end
   end

   // Pointer, element index and occupancy bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
         r_idx    <= '0;
      end else begin
         if (w_accept) begin
            r_wr_ptr <= ~r_wr_ptr;
         end
         if (w_hs) begin
            r_idx <= w_at_last ? '0 : r_idx + 1'b1;
         end
         if (w_release) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         // Accept and release together leave occupancy unchanged: the new tile
         // lands in the free bank while the other one is being given back.
         case ({w_accept, w_release})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_matmul_result_drain.sv
// Bench for matmul_result_drain: scoreboard of expected elements filled on tile accept.
// Inputs are driven and outputs sampled on the falling clock edge.
// Each scenario task performs its own comparisons against the scoreboard.
module tb_matmul_result_drain;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int NE = N * N;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [1:0]    r;
      logic [1:0]    c;
      logic          l;
   } exp_t;

   logic              clk;
   logic              rst;
   logic [NE*DW-1:0]  in_tile;
   logic              in_valid;
   logic              in_ready;
   logic [DW-1:0]     out_data;
   logic [1:0]        out_row;
   logic [1:0]        out_col;
   logic              out_last;
   logic              out_valid;
   logic              out_ready;
   logic              busy;

   exp_t q[$];
   int   n_vec;
   int   n_err;

   matmul_result_drain #(.N(N), .DW(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_tile   (in_tile),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_row   (out_row),
      .out_col   (out_col),
      .out_last  (out_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Tile whose element k holds base + k*step
   function automatic logic [NE*DW-1:0] make_tile(input int base, input int step);
      logic [NE*DW-1:0] t;
      for (int k = 0; k < NE; k++) begin
         t[k*DW +: DW] = DW'(base + k * step);
      end
      return t;
   endfunction

   // Expected element k of a tile as it should appear on the output
   function automatic exp_t exp_of(input logic [NE*DW-1:0] t, input int k);
      exp_t e;
      e.d = t[k*DW +: DW];
`ifdef DRAIN_RELU_EN
      if (e.d[DW-1]) e.d = '0;
`endif
      e.r = 2'(k / N);
      e.c = 2'(k % N);
      e.l = (k == NE - 1);
      return e;
   endfunction

   task automatic push_tile(input logic [NE*DW-1:0] t);
      for (int k = 0; k < NE; k++) q.push_back(exp_of(t, k));
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) begin
         @(negedge clk);
         in_tile   = {16{$urandom()}};
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      n_vec++;
      if ({in_ready, out_valid, out_last, busy, out_data, out_row, out_col} !==
          {1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 2'd0, 2'd0}) begin
         n_err++;
         $display("FAIL reset_state: rdy=%b vld=%b last=%b busy=%b data=%h row=%0d col=%0d, required rdy=1 and all else 0",
                  in_ready, out_valid, out_last, busy, out_data, out_row, out_col);
      end
      rst      = 1'b0;
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         out_ready = 1'($urandom_range(0, 1));
         n_vec++;
         if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: out_valid=%b required 0", out_valid);
         end
      end
   endtask

   task automatic test_single;
      logic [NE*DW-1:0] t;
      exp_t e;
      t = make_tile(-5, 1);
      @(negedge clk);
      in_tile = t; in_valid = 1'b1; out_ready = 1'b1;
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL single_in_ready: got %b required 1", in_ready);
      end
      push_tile(t);
      for (int i = 0; i < NE; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         n_vec++;
         if (out_valid !== 1'b1) begin
            n_err++; $display("FAIL single_valid: cycle %0d out_valid=%b required 1", i + 1, out_valid);
         end else if (q.size() == 0) begin
            n_err++; $display("FAIL single_extra: unexpected element %h", out_data);
         end else begin
            e = q.pop_front();
            if ({out_data, out_row, out_col, out_last} !== {e.d, e.r, e.c, e.l}) begin
               n_err++;
               $display("FAIL single_elem: got d=%h r=%0d c=%0d l=%b required d=%h r=%0d c=%0d l=%b",
                        out_data, out_row, out_col, out_last, e.d, e.r, e.c, e.l);
            end
         end
      end
      @(negedge clk);
      n_vec++;
      if ({out_valid, busy, out_data} !== {1'b0, 1'b0, 32'd0}) begin
         n_err++; $display("FAIL single_done: vld=%b busy=%b data=%h required 0 0 0", out_valid, busy, out_data);
      end
   endtask

   task automatic test_backpressure;
      logic [NE*DW-1:0] t;
      logic [36:0] held;
      logic stalled;
      int hs;
      exp_t e;
      t = make_tile(-5, 1);
      @(negedge clk);
      in_tile = t; in_valid = 1'b1; out_ready = 1'b0;
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL bp_in_ready: got %b required 1", in_ready);
      end
      push_tile(t);
      hs = 0; stalled = 1'b0; held = '0;
      for (int cyc = 0; cyc < 100 && hs < NE; cyc++) begin
         @(negedge clk);
         in_valid = 1'b0;
         if (stalled) begin
            n_vec++;
            if ({out_data, out_row, out_col, out_last} !== held) begin
               n_err++; $display("FAIL bp_stall_hold: got %h required %h", {out_data, out_row, out_col, out_last}, held);
            end
         end
         out_ready = (cyc % 3 == 0);
         n_vec++;
         if (out_valid !== 1'b1) begin
            n_err++; $display("FAIL bp_valid: cycle %0d out_valid=%b required 1", cyc, out_valid);
            stalled = 1'b0;
         end else begin
            held    = {out_data, out_row, out_col, out_last};
            stalled = !out_ready;
            if (out_ready) begin
               hs++;
               e = q.pop_front();
               if ({out_data, out_row, out_col, out_last} !== {e.d, e.r, e.c, e.l}) begin
                  n_err++;
                  $display("FAIL bp_elem: got d=%h r=%0d c=%0d l=%b required d=%h r=%0d c=%0d l=%b",
                           out_data, out_row, out_col, out_last, e.d, e.r, e.c, e.l);
               end
            end
         end
      end
      n_vec++;
      if (hs != NE) begin
         n_err++; $display("FAIL bp_count: %0d handshakes required %0d", hs, NE);
      end
      @(negedge clk);
      out_ready = 1'b1;
      n_vec++;
      if ({out_valid, busy} !== 2'b00) begin
         n_err++; $display("FAIL bp_done: vld=%b busy=%b required 0 0", out_valid, busy);
      end
      q.delete();
   endtask

   task automatic test_pingpong;
      logic [NE*DW-1:0] t0, t1, t2;
      logic t2_pending, t0_done;
      int hs;
      exp_t e;
      t0 = make_tile(1000, 1);
      t1 = make_tile(-2000, 3);
      t2 = make_tile(50, -7);
      @(negedge clk);
      out_ready = 1'b0; in_tile = t0; in_valid = 1'b1;
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL pp_t0_ready: got %b required 1", in_ready);
      end
      push_tile(t0);
      @(negedge clk);
      in_tile = t1;
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL pp_t1_ready: got %b required 1", in_ready);
      end
      push_tile(t1);
      @(negedge clk);
      in_tile = t2;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         n_vec++;
         if ({in_ready, out_valid, busy, out_row, out_col} !== {1'b0, 1'b1, 1'b1, 2'd0, 2'd0}) begin
            n_err++;
            $display("FAIL pp_full: rdy=%b vld=%b busy=%b row=%0d col=%0d required 0 1 1 0 0",
                     in_ready, out_valid, busy, out_row, out_col);
         end
      end
      t2_pending = 1'b1; t0_done = 1'b0; hs = 0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 200 && hs < 3 * NE; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (!t2_pending) in_valid = 1'b0;
         if (t2_pending) begin
            n_vec++;
            if (in_ready !== t0_done) begin
               n_err++; $display("FAIL pp_t2_ready: handshake %0d in_ready=%b required %b", hs, in_ready, t0_done);
            end
            if (in_ready) begin
               push_tile(t2);
               t2_pending = 1'b0;
            end
         end
         n_vec++;
         if (out_valid !== 1'b1) begin
            n_err++; $display("FAIL pp_gap: handshake %0d out_valid=%b required 1", hs, out_valid);
         end else begin
            e = q.pop_front();
            hs++;
            if ({out_data, out_row, out_col, out_last} !== {e.d, e.r, e.c, e.l}) begin
               n_err++;
               $display("FAIL pp_elem: got d=%h r=%0d c=%0d l=%b required d=%h r=%0d c=%0d l=%b",
                        out_data, out_row, out_col, out_last, e.d, e.r, e.c, e.l);
            end
            if (hs == NE) t0_done = 1'b1;
         end
      end
      n_vec++;
      if (hs != 3 * NE || t2_pending) begin
         n_err++; $display("FAIL pp_count: %0d handshakes (t2 pending %b) required %0d", hs, t2_pending, 3 * NE);
      end
      @(negedge clk);
      in_valid = 1'b0;
      n_vec++;
      if ({out_valid, busy} !== 2'b00) begin
         n_err++; $display("FAIL pp_done: vld=%b busy=%b required 0 0", out_valid, busy);
      end
      q.delete();
   endtask

   task automatic test_simultaneous;
      logic [NE*DW-1:0] ta, tb;
      logic sent_b, just_sent;
      int hs;
      exp_t e;
      ta = make_tile(7, 11);
      tb = make_tile(-300, 5);
      @(negedge clk);
      in_tile = ta; in_valid = 1'b1; out_ready = 1'b1;
      push_tile(ta);
      sent_b = 1'b0; just_sent = 1'b0; hs = 0;
      for (int cyc = 0; cyc < 100 && hs < 2 * NE; cyc++) begin
         @(negedge clk);
         in_valid = 1'b0;
         if (just_sent) begin
            n_vec++;
            if ({in_ready, busy} !== 2'b11) begin
               n_err++; $display("FAIL simul_count: rdy=%b busy=%b required 1 1", in_ready, busy);
            end
            just_sent = 1'b0;
         end
         n_vec++;
         if (out_valid !== 1'b1) begin
            n_err++; $display("FAIL simul_valid: handshake %0d out_valid=%b required 1", hs, out_valid);
         end else begin
            e = q.pop_front();
            hs++;
            if ({out_data, out_row, out_col, out_last} !== {e.d, e.r, e.c, e.l}) begin
               n_err++;
               $display("FAIL simul_elem: got d=%h r=%0d c=%0d l=%b required d=%h r=%0d c=%0d l=%b",
                        out_data, out_row, out_col, out_last, e.d, e.r, e.c, e.l);
            end
            if (e.l && !sent_b) begin
               in_tile = tb; in_valid = 1'b1;
               n_vec++;
               if (in_ready !== 1'b1) begin
                  n_err++; $display("FAIL simul_in_ready: got %b required 1", in_ready);
               end
               push_tile(tb);
               sent_b = 1'b1; just_sent = 1'b1;
            end
         end
      end
      n_vec++;
      if (hs != 2 * NE) begin
         n_err++; $display("FAIL simul_total: %0d handshakes required %0d", hs, 2 * NE);
      end
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++; $display("FAIL simul_done: out_valid=%b required 0", out_valid);
      end
      q.delete();
   endtask

   task automatic test_reset_mid;
      logic [NE*DW-1:0] t;
      exp_t e;
      t = make_tile(-100, 9);
      @(negedge clk);
      in_tile = t; in_valid = 1'b1; out_ready = 1'b1;
      push_tile(t);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         n_vec++;
         if (out_valid !== 1'b1) begin
            n_err++; $display("FAIL rmid_valid: element %0d out_valid=%b required 1", i, out_valid);
         end else begin
            e = q.pop_front();
            if ({out_data, out_row, out_col, out_last} !== {e.d, e.r, e.c, e.l}) begin
               n_err++;
               $display("FAIL rmid_elem: got d=%h r=%0d c=%0d l=%b required d=%h r=%0d c=%0d l=%b",
                        out_data, out_row, out_col, out_last, e.d, e.r, e.c, e.l);
            end
         end
      end
      @(negedge clk);
      rst = 1'b1;
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      n_vec++;
      if ({out_valid, busy, in_ready, out_data} !== {1'b0, 1'b0, 1'b1, 32'd0}) begin
         n_err++; $display("FAIL rmid_reset: vld=%b busy=%b rdy=%b data=%h required 0 0 1 0",
                           out_valid, busy, in_ready, out_data);
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n_vec++;
         if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL rmid_remnant: cycle %0d out_valid=%b data=%h required 0", i, out_valid, out_data);
         end
      end
   endtask

   task automatic test_relu;
      logic [NE*DW-1:0] t;
      exp_t e;
      t = make_tile(-8, 1);
      t[0*DW +: DW] = 32'hFFFF_FFF0;
      t[1*DW +: DW] = 32'h0000_0010;
      @(negedge clk);
      in_tile = t; in_valid = 1'b1; out_ready = 1'b1;
      push_tile(t);
      for (int i = 0; i < NE; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         n_vec++;
         if (out_valid !== 1'b1) begin
            n_err++; $display("FAIL relu_valid: element %0d out_valid=%b required 1", i, out_valid);
         end else begin
            e = q.pop_front();
            if ({out_data, out_row, out_col, out_last} !== {e.d, e.r, e.c, e.l}) begin
               n_err++;
               $display("FAIL relu_elem: got d=%h r=%0d c=%0d l=%b required d=%h r=%0d c=%0d l=%b",
                        out_data, out_row, out_col, out_last, e.d, e.r, e.c, e.l);
            end
         end
      end
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++; $display("FAIL relu_done: out_valid=%b required 0", out_valid);
      end
      q.delete();
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_tile = '0;
      test_reset();
      test_single();
      test_backpressure();
      test_pingpong();
      test_simultaneous();
      test_reset_mid();
      test_relu();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
